// File: rtl/dcache_sweep_ctrl.sv
// Invalidation sequencer: walks every set of the L1 D-cache and clears valid/dirty for all ways.
// Optional define DCACHE_SWEEP_THROTTLE_EN inserts a one-cycle gap after every non-final write.
module dcache_sweep_ctrl #(
    parameter int unsigned SET_ASSOC   = 8,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned BYTE_OFFSET = 4,
    parameter int unsigned NUM_WORDS   = 2**(INDEX_WIDTH-BYTE_OFFSET)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     gnt_i,
    output logic [SET_ASSOC-1:0]     req_o,
    output logic [INDEX_WIDTH-1:0]   addr_o,
    output logic                     we_o,
    output logic [8*SET_ASSOC-1:0]   vldrty_be_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

`ifdef DCACHE_SWEEP_THROTTLE_EN
    typedef enum logic [2:0] {
        RST_DLY = 3'd0, SWEEP = 3'd1, GAP = 3'd2, DONE = 3'd3, IDLE = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        RST_DLY = 3'd0, SWEEP = 3'd1, DONE = 3'd3, IDLE = 3'd4
    } state_e;
`endif

    // Valid and dirty occupy the two lowest byte lanes of each way's slot.
    function automatic logic [8*SET_ASSOC-1:0] vldrty_mask();
        logic [8*SET_ASSOC-1:0] m;
        m = '0;
        for (int i = 0; i < int'(SET_ASSOC); i++) begin
            m[8*i]   = 1'b1;
            m[8*i+1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] idx_to_addr(input logic [IDX_W-1:0] idx);
        logic [INDEX_WIDTH+IDX_W-1:0] wide;
        wide = {{INDEX_WIDTH{1'b0}}, idx} << BYTE_OFFSET;
        return wide[INDEX_WIDTH-1:0];
    endfunction

    state_e                   state_r, state_nxt_s;
    logic [IDX_W-1:0]         idx_r, idx_nxt_s;
    logic                     pending_r, pending_nxt_s;

    logic                     sweeping_nxt_s;
    logic [SET_ASSOC-1:0]     req_r;
    logic [INDEX_WIDTH-1:0]   addr_r;
    logic                     we_r;
    logic [8*SET_ASSOC-1:0]   be_r;
    logic                     busy_r;
    logic                     done_r;

    // Next-state, index and pending-request logic.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        pending_nxt_s = pending_r;
        case (state_r)
            RST_DLY: begin
                if (start_i) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                state_nxt_s = SWEEP;
                idx_nxt_s   = '0;
            end
            SWEEP: begin
                if (start_i) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                if (gnt_i) begin
                    if (idx_r == LAST_IDX) begin
                        idx_nxt_s = '0;
                        if (pending_r) begin
                            // Request arrived mid-pass: a fresh full pass starts now.
                            pending_nxt_s = 1'b0;
                            state_nxt_s   = SWEEP;
                        end else begin
                            state_nxt_s   = DONE;
                        end
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
`ifdef DCACHE_SWEEP_THROTTLE_EN
                        state_nxt_s = GAP;
`else
                        state_nxt_s = SWEEP;
`endif
                    end
                end else begin
                    state_nxt_s = SWEEP;
                end
            end
`ifdef DCACHE_SWEEP_THROTTLE_EN
            GAP: begin
                if (start_i) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                state_nxt_s = SWEEP;
            end
`endif
            DONE: begin
                // A request landing on the final grant is still honoured here.
                if (start_i || pending_r) begin
                    state_nxt_s   = SWEEP;
                    idx_nxt_s     = '0;
                    pending_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = SWEEP;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s   = RST_DLY;
                idx_nxt_s     = '0;
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    assign sweeping_nxt_s = (state_nxt_s == SWEEP);

    // State, index and registered-output flops; outputs are precomputed from next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= RST_DLY;
            idx_r     <= '0;
            pending_r <= 1'b0;
            req_r     <= '0;
            addr_r    <= '0;
            we_r      <= 1'b0;
            be_r      <= '0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            pending_r <= pending_nxt_s;
            req_r     <= {SET_ASSOC{sweeping_nxt_s}};
            addr_r    <= sweeping_nxt_s ? idx_to_addr(idx_nxt_s) : '0;
            we_r      <= sweeping_nxt_s;
            be_r      <= sweeping_nxt_s ? vldrty_mask() : '0;
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_nxt_s == DONE);
        end
    end

    assign req_o       = req_r;
    assign addr_o      = addr_r;
    assign we_o        = we_r;
    assign vldrty_be_o = be_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_dcache_sweep_ctrl.sv
// Directed self-checking bench for dcache_sweep_ctrl (default 8 ways, 256 sets).
// Expectations follow DCACHE_SWEEP_THROTTLE_EN when the bench is built with it defined.
module tb_dcache_sweep_ctrl;

    localparam int NW = 256;
    localparam logic [63:0] BE_ALL = 64'h0303030303030303;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        gnt_i;
    logic [7:0]  req_o;
    logic [11:0] addr_o;
    logic        we_o;
    logic [63:0] vldrty_be_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int grants = 0;

    always #5 clk_i = ~clk_i;

    dcache_sweep_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .gnt_i       (gnt_i),
        .req_o       (req_o),
        .addr_o      (addr_o),
        .we_o        (we_o),
        .vldrty_be_o (vldrty_be_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always @(posedge clk_i) begin
        if (we_o && gnt_i) grants++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Current cycle must already be the request for index first_k; full grant assumed.
    task automatic check_sweep(input int first_k);
        logic [63:0] ea;
        for (int k = first_k; k < NW; k++) begin
            if (k != first_k) step();
            ea = 64'(k) << 4;
            chk("sweep_req", 64'(req_o), 64'hFF);
            chk("sweep_addr", 64'(addr_o), ea);
            chk("sweep_nodone", 64'(done_o), 64'd0);
            if (k == first_k) begin
                chk("sweep_we", 64'(we_o), 64'd1);
                chk("sweep_be", vldrty_be_o, BE_ALL);
                chk("sweep_busy", 64'(busy_o), 64'd1);
            end
`ifdef DCACHE_SWEEP_THROTTLE_EN
            if (k < NW - 1) begin
                step();
                chk("gap_req", 64'(req_o), 64'd0);
                chk("gap_busy", 64'(busy_o), 64'd1);
            end
`endif
        end
        step();
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("done_req", 64'(req_o), 64'd0);
        chk("done_busy", 64'(busy_o), 64'd1);
    endtask

    task automatic advance(input int k);
        int n;
        n = 0;
        while (!(req_o == 8'hFF && addr_o == 12'(k << 4)) && n < 2000) begin
            step();
            n++;
        end
        chk("advance_reach", 64'(n < 2000), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk("done_seen", 64'(done_o), 64'd1);
    endtask

    initial begin
        int wrap_seen;
        int last_seen;
        int n;
        int g0;

        rst_ni  = 1'b1;
        start_i = 1'b0;
        gnt_i   = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_req", 64'(req_o), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_be", vldrty_be_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        repeat (3) step();
        chk("rst_hold_busy", 64'(busy_o), 64'd1);

        // Automatic sweep after reset release.
        rst_ni = 1'b1;
        chk("rstdly_req", 64'(req_o), 64'd0);
        step();
        check_sweep(0);
        step();
        chk("post_done", 64'(done_o), 64'd0);
        chk("post_busy", 64'(busy_o), 64'd0);
        step();
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_req", 64'(req_o), 64'd0);

        // One-cycle start from IDLE gives one full sweep.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_sweep(0);
        step();
        chk("idle2_busy", 64'(busy_o), 64'd0);

        // Grant stall at index 5.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        advance(5);
        gnt_i = 1'b0;
        repeat (3) begin
            step();
            chk("stall_addr", 64'(addr_o), 64'h050);
            chk("stall_req", 64'(req_o), 64'hFF);
        end
        gnt_i = 1'b1;
        step();
`ifdef DCACHE_SWEEP_THROTTLE_EN
        chk("stall_gap", 64'(req_o), 64'd0);
        step();
`endif
        chk("resume_addr", 64'(addr_o), 64'h060);
        chk("resume_req", 64'(req_o), 64'hFF);
        wait_done();
        step();
        chk("stall_idle", 64'(busy_o), 64'd0);

        // Start mid-sweep forces a second full pass.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        g0 = grants;
        advance(100);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wrap_seen = 0;
        last_seen = 0;
        n = 0;
        while (done_o !== 1'b1 && n < 3000) begin
            if (req_o == 8'hFF && addr_o == 12'hFF0) last_seen = 1;
            if (last_seen == 1 && req_o == 8'hFF && addr_o == 12'h000) wrap_seen = 1;
            step();
            n++;
        end
        chk("pend_done", 64'(done_o), 64'd1);
        chk("pend_wrap", 64'(wrap_seen), 64'd1);
        chk("pend_grants", 64'(grants - g0), 64'd512);
        step();
        chk("pend_single_done", 64'(done_o), 64'd0);
        chk("pend_idle", 64'(busy_o), 64'd0);

        // Asynchronous reset at index 40, then clean restart.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        advance(40);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_req", 64'(req_o), 64'd0);
        chk("arst_addr", 64'(addr_o), 64'd0);
        chk("arst_we", 64'(we_o), 64'd0);
        chk("arst_be", vldrty_be_o, 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd1);
        chk("arst_done", 64'(done_o), 64'd0);
        step();
        step();
        rst_ni = 1'b1;
        chk("arst_rel_done", 64'(done_o), 64'd0);
        step();
        check_sweep(0);
        step();
        chk("arst_idle", 64'(busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
